// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types for the ID-stage hazard unit (forward selects,
//               register bank select).
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam int c_NUM_REGS   = 32;
    localparam int c_REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        NO_FORWARD            = 3'd0,
        FWD_EX_ALU_RES_TO_ID  = 3'd1,
        FWD_MEM_ALU_RES_TO_ID = 3'd2,
        FWD_MEM_RDATA_TO_ID   = 3'd3,
        FWD_WB_ALU_RES_TO_ID  = 3'd4,
        FWD_WB_RDATA_TO_ID    = 3'd5,
        FWD_LAT_WB_TO_ID      = 3'd6
    } forward_t;

    typedef enum logic [0:0] {
        REG_BANK_X = 1'b0,
        REG_BANK_F = 1'b1
    } reg_bank_mux_t;

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_bank.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_bank
// Description : 32-entry pending-write vector for one register bank.
//               Flush beats set, set beats clear on the same entry.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_bank
    import hazard_scoreboard_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_set_en,
    input  logic [c_REG_ADDR_W-1:0] i_set_addr,
    input  logic                    i_clr_en,
    input  logic [c_REG_ADDR_W-1:0] i_clr_addr,
    output logic [c_NUM_REGS-1:0]   o_pending
);

    logic [c_NUM_REGS-1:0] r_pending;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pending <= '0;
        end else begin
            if (i_clr_en) r_pending[i_clr_addr] <= 1'b0;
            if (i_set_en) r_pending[i_set_addr] <= 1'b1;
        end
    end

    assign o_pending = r_pending;

endmodule : hazard_scoreboard_bank
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage forwarding select and stall generation with a
//               per-bank scoreboard of outstanding long-latency writes.
//               Optional macro HAZARD_LAT_WB_BYPASS_EN enables same-cycle
//               bypass of the long-latency writeback port.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int                   NUM_SRC         = 3,
    parameter int                   NUM_BANKS       = 2,
    parameter int                   BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter logic [NUM_BANKS-1:0] ZERO_BANK_MASK  = 2'b01,
    parameter int                   MAX_OUTSTANDING = 4,
    parameter int                   CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_SRC-1:0][c_REG_ADDR_W-1:0]   rs_addr_id_i,
    input  logic [NUM_SRC-1:0][BANK_W-1:0]         rs_bank_id_i,
    input  logic [NUM_SRC-1:0]                     rs_used_id_i,
    input  logic [c_REG_ADDR_W-1:0]                rd_addr_id_i,
    input  logic [BANK_W-1:0]                      rd_bank_id_i,
    input  logic                                   rd_wen_id_i,
    input  logic                                   issue_valid_i,
    input  logic                                   long_lat_id_i,
    input  logic [c_REG_ADDR_W-1:0]                rd_addr_ex_i,
    input  logic [BANK_W-1:0]                      rd_bank_ex_i,
    input  logic                                   reg_alu_wen_ex_i,
    input  logic                                   reg_mem_wen_ex_i,
    input  logic [c_REG_ADDR_W-1:0]                rd_addr_mem_i,
    input  logic [BANK_W-1:0]                      rd_bank_mem_i,
    input  logic                                   reg_alu_wen_mem_i,
    input  logic                                   reg_mem_wen_mem_i,
    input  logic [c_REG_ADDR_W-1:0]                rd_addr_wb_i,
    input  logic [BANK_W-1:0]                      rd_bank_wb_i,
    input  logic                                   reg_alu_wen_wb_i,
    input  logic                                   reg_mem_wen_wb_i,
    input  logic                                   lat_wb_valid_i,
    input  logic [c_REG_ADDR_W-1:0]                lat_wb_addr_i,
    input  logic [BANK_W-1:0]                      lat_wb_bank_i,
    input  logic                                   flush_pending_i,
    output forward_t [NUM_SRC-1:0]                 fwd_o,
    output logic                                   stall_id_o,
    output logic [CNT_W-1:0]                       pending_cnt_o,
    output logic                                   sb_full_o
);

`ifdef HAZARD_LAT_WB_BYPASS_EN
    localparam logic c_LAT_BYPASS = 1'b1;
`else
    localparam logic c_LAT_BYPASS = 1'b0;
`endif

    logic [c_NUM_REGS-1:0]  w_pend [NUM_BANKS];
    logic [NUM_BANKS-1:0]   w_set_en;
    logic [NUM_BANKS-1:0]   w_clr_en;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_full;
    logic                   w_alloc;
    logic                   w_stall;
    forward_t [NUM_SRC-1:0] w_fwd;
    logic                   w_load_use, w_raw, w_waw, w_full_stall;
    logic                   w_src_zero, w_src_pend, w_rd_pend, w_lat_rd;
    logic                   w_hit_ex, w_hit_mem, w_hit_wb, w_hit_lat;

    assign w_full  = (r_cnt == CNT_W'(MAX_OUTSTANDING));
    assign w_alloc = issue_valid_i && !w_stall && long_lat_id_i && rd_wen_id_i;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        // Hardwired-zero entries are never tracked.
        assign w_set_en[b] = w_alloc && (rd_bank_id_i == BANK_W'(b))
                             && !(ZERO_BANK_MASK[b] && (rd_addr_id_i == '0));
        assign w_clr_en[b] = lat_wb_valid_i && (lat_wb_bank_i == BANK_W'(b));

        hazard_scoreboard_bank u_bank (
            .clk        (clk_i),
            .rst        (rst_i),
            .i_flush    (flush_pending_i),
            .i_set_en   (w_set_en[b]),
            .i_set_addr (rd_addr_id_i),
            .i_clr_en   (w_clr_en[b]),
            .i_clr_addr (lat_wb_addr_i),
            .o_pending  (w_pend[b])
        );
    end

    always_comb begin
        w_load_use = 1'b0;
        w_raw      = 1'b0;
        w_src_zero = 1'b0;
        w_src_pend = 1'b0;
        w_hit_ex   = 1'b0;
        w_hit_mem  = 1'b0;
        w_hit_wb   = 1'b0;
        w_hit_lat  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_fwd[s]   = NO_FORWARD;
            w_src_zero = 1'b0;
            w_src_pend = 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (rs_bank_id_i[s] == BANK_W'(b)) begin
                    if (ZERO_BANK_MASK[b] && (rs_addr_id_i[s] == '0)) w_src_zero = 1'b1;
                    if (w_pend[b][rs_addr_id_i[s]])                    w_src_pend = 1'b1;
                end
            end
            w_hit_ex  = rs_used_id_i[s] && !w_src_zero &&
                        (rs_addr_id_i[s] == rd_addr_ex_i)  && (rs_bank_id_i[s] == rd_bank_ex_i);
            w_hit_mem = rs_used_id_i[s] && !w_src_zero &&
                        (rs_addr_id_i[s] == rd_addr_mem_i) && (rs_bank_id_i[s] == rd_bank_mem_i);
            w_hit_wb  = rs_used_id_i[s] && !w_src_zero &&
                        (rs_addr_id_i[s] == rd_addr_wb_i)  && (rs_bank_id_i[s] == rd_bank_wb_i);
            w_hit_lat = rs_used_id_i[s] && !w_src_zero && lat_wb_valid_i &&
                        (rs_addr_id_i[s] == lat_wb_addr_i) && (rs_bank_id_i[s] == lat_wb_bank_i);

            if (w_hit_ex && reg_alu_wen_ex_i)              w_fwd[s] = FWD_EX_ALU_RES_TO_ID;
            else if (w_hit_mem && reg_alu_wen_mem_i)       w_fwd[s] = FWD_MEM_ALU_RES_TO_ID;
            else if (w_hit_mem && reg_mem_wen_mem_i)       w_fwd[s] = FWD_MEM_RDATA_TO_ID;
            else if (w_hit_wb && reg_alu_wen_wb_i)         w_fwd[s] = FWD_WB_ALU_RES_TO_ID;
            else if (w_hit_wb && reg_mem_wen_wb_i)         w_fwd[s] = FWD_WB_RDATA_TO_ID;
            else if (c_LAT_BYPASS && w_hit_lat)            w_fwd[s] = FWD_LAT_WB_TO_ID;

            if (w_hit_ex && reg_mem_wen_ex_i) w_load_use = 1'b1;
            if (rs_used_id_i[s] && !w_src_zero && w_src_pend && !(c_LAT_BYPASS && w_hit_lat))
                w_raw = 1'b1;
        end
    end

    always_comb begin
        w_rd_pend = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if ((rd_bank_id_i == BANK_W'(b)) && w_pend[b][rd_addr_id_i]) w_rd_pend = 1'b1;
        end
        w_lat_rd     = lat_wb_valid_i && (lat_wb_addr_i == rd_addr_id_i) &&
                       (lat_wb_bank_i == rd_bank_id_i);
        w_waw        = rd_wen_id_i && w_rd_pend && !(c_LAT_BYPASS && w_lat_rd);
        w_full_stall = long_lat_id_i && w_full && !(c_LAT_BYPASS && lat_wb_valid_i);
    end

    assign w_stall = w_load_use | w_raw | w_waw | w_full_stall;

    // A same-cycle allocate and writeback cancel out in the counter.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_pending_i) begin
            r_cnt <= '0;
        end else if (w_alloc && !lat_wb_valid_i) begin
            if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_alloc && lat_wb_valid_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign fwd_o         = w_fwd;
    assign stall_id_o    = w_stall;
    assign pending_cnt_o = r_cnt;
    assign sb_full_o     = w_full;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed scenarios plus randomized traffic against a
//               behavioural model of the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NS   = 3;
    localparam int NB   = 2;
    localparam int BW   = 1;
    localparam int MAXO = 4;
    localparam int CW   = 3;
`ifdef HAZARD_LAT_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_i;
    logic [NS-1:0][4:0]    rs_addr_id_i;
    logic [NS-1:0][BW-1:0] rs_bank_id_i;
    logic [NS-1:0]         rs_used_id_i;
    logic [4:0]            rd_addr_id_i, rd_addr_ex_i, rd_addr_mem_i, rd_addr_wb_i, lat_wb_addr_i;
    logic [BW-1:0]         rd_bank_id_i, rd_bank_ex_i, rd_bank_mem_i, rd_bank_wb_i, lat_wb_bank_i;
    logic                  rd_wen_id_i, issue_valid_i, long_lat_id_i;
    logic                  reg_alu_wen_ex_i, reg_mem_wen_ex_i, reg_alu_wen_mem_i, reg_mem_wen_mem_i;
    logic                  reg_alu_wen_wb_i, reg_mem_wen_wb_i;
    logic                  lat_wb_valid_i, flush_pending_i;
    forward_t [NS-1:0]     fwd_o;
    logic                  stall_id_o, sb_full_o;
    logic [CW-1:0]         pending_cnt_o;

    hazard_scoreboard dut (
        .clk_i(clk), .rst_i(rst_i),
        .rs_addr_id_i(rs_addr_id_i), .rs_bank_id_i(rs_bank_id_i), .rs_used_id_i(rs_used_id_i),
        .rd_addr_id_i(rd_addr_id_i), .rd_bank_id_i(rd_bank_id_i), .rd_wen_id_i(rd_wen_id_i),
        .issue_valid_i(issue_valid_i), .long_lat_id_i(long_lat_id_i),
        .rd_addr_ex_i(rd_addr_ex_i), .rd_bank_ex_i(rd_bank_ex_i),
        .reg_alu_wen_ex_i(reg_alu_wen_ex_i), .reg_mem_wen_ex_i(reg_mem_wen_ex_i),
        .rd_addr_mem_i(rd_addr_mem_i), .rd_bank_mem_i(rd_bank_mem_i),
        .reg_alu_wen_mem_i(reg_alu_wen_mem_i), .reg_mem_wen_mem_i(reg_mem_wen_mem_i),
        .rd_addr_wb_i(rd_addr_wb_i), .rd_bank_wb_i(rd_bank_wb_i),
        .reg_alu_wen_wb_i(reg_alu_wen_wb_i), .reg_mem_wen_wb_i(reg_mem_wen_wb_i),
        .lat_wb_valid_i(lat_wb_valid_i), .lat_wb_addr_i(lat_wb_addr_i), .lat_wb_bank_i(lat_wb_bank_i),
        .flush_pending_i(flush_pending_i),
        .fwd_o(fwd_o), .stall_id_o(stall_id_o), .pending_cnt_o(pending_cnt_o), .sb_full_o(sb_full_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference state: set of outstanding (bank, reg) writes and their count.
    bit m_pend [NB][32];
    int m_cnt;

    function automatic bit is_zero(input int b, input int a);
        return (b == 0) && (a == 0);
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < 32; r++) m_pend[b][r] = 1'b0;
        m_cnt = 0;
    endtask

    task automatic idle();
        rst_i = 0; rs_addr_id_i = '0; rs_bank_id_i = '0; rs_used_id_i = '0;
        rd_addr_id_i = 0; rd_bank_id_i = 0; rd_wen_id_i = 0; issue_valid_i = 0; long_lat_id_i = 0;
        rd_addr_ex_i = 0; rd_bank_ex_i = 0; reg_alu_wen_ex_i = 0; reg_mem_wen_ex_i = 0;
        rd_addr_mem_i = 0; rd_bank_mem_i = 0; reg_alu_wen_mem_i = 0; reg_mem_wen_mem_i = 0;
        rd_addr_wb_i = 0; rd_bank_wb_i = 0; reg_alu_wen_wb_i = 0; reg_mem_wen_wb_i = 0;
        lat_wb_valid_i = 0; lat_wb_addr_i = 0; lat_wb_bank_i = 0; flush_pending_i = 0;
    endtask

    // Inputs were driven just after a falling edge: check, advance model, move to next falling edge.
    task automatic step();
        int       ef [NS];
        int       sa [3];
        int       sb [3];
        bit       salu [3];
        bit       smem [3];
        forward_t alu_c [3];
        forward_t mem_c [3];
        bit       lu, raw, waw, full, est, set, latm, done;
        int       a, b, ra, rb;
        #1;
        alu_c = '{FWD_EX_ALU_RES_TO_ID, FWD_MEM_ALU_RES_TO_ID, FWD_WB_ALU_RES_TO_ID};
        mem_c = '{NO_FORWARD, FWD_MEM_RDATA_TO_ID, FWD_WB_RDATA_TO_ID};
        sa    = '{int'(rd_addr_ex_i), int'(rd_addr_mem_i), int'(rd_addr_wb_i)};
        sb    = '{int'(rd_bank_ex_i), int'(rd_bank_mem_i), int'(rd_bank_wb_i)};
        salu  = '{reg_alu_wen_ex_i, reg_alu_wen_mem_i, reg_alu_wen_wb_i};
        smem  = '{reg_mem_wen_ex_i, reg_mem_wen_mem_i, reg_mem_wen_wb_i};
        lu = 0; raw = 0;
        for (int s = 0; s < NS; s++) begin
            ef[s] = NO_FORWARD;
            a = int'(rs_addr_id_i[s]);
            b = int'(rs_bank_id_i[s]);
            if (rs_used_id_i[s] && !is_zero(b, a)) begin
                done = 0;
                for (int k = 0; k < 3; k++) begin
                    if (!done && sa[k] == a && sb[k] == b) begin
                        if (salu[k])      begin ef[s] = alu_c[k]; done = 1; end
                        else if (smem[k] && k > 0) begin ef[s] = mem_c[k]; done = 1; end
                    end
                end
                latm = lat_wb_valid_i && (int'(lat_wb_addr_i) == a) && (int'(lat_wb_bank_i) == b);
                if (!done && BYP && latm) ef[s] = FWD_LAT_WB_TO_ID;
                if (sa[0] == a && sb[0] == b && smem[0]) lu = 1;
                if (m_pend[b][a] && !(BYP && latm)) raw = 1;
            end
        end
        ra   = int'(rd_addr_id_i);
        rb   = int'(rd_bank_id_i);
        latm = lat_wb_valid_i && (int'(lat_wb_addr_i) == ra) && (int'(lat_wb_bank_i) == rb);
        waw  = rd_wen_id_i && m_pend[rb][ra] && !(BYP && latm);
        full = long_lat_id_i && (m_cnt == MAXO) && !(BYP && lat_wb_valid_i);
        est  = lu | raw | waw | full;

        for (int s = 0; s < NS; s++) check($sformatf("fwd%0d", s), 32'(fwd_o[s]), 32'(ef[s]));
        check("stall", 32'(stall_id_o), 32'(est));
        check("cnt",   32'(pending_cnt_o), 32'(m_cnt));
        check("full",  32'(sb_full_o), 32'(m_cnt == MAXO));

        if (rst_i || flush_pending_i) begin
            model_clear();
        end else begin
            set = issue_valid_i && !est && long_lat_id_i && rd_wen_id_i;
            if (lat_wb_valid_i) m_pend[int'(lat_wb_bank_i)][int'(lat_wb_addr_i)] = 1'b0;
            if (set && !is_zero(rb, ra)) m_pend[rb][ra] = 1'b1;
            if (set && !lat_wb_valid_i) m_cnt++;
            else if (!set && lat_wb_valid_i && m_cnt > 0) m_cnt--;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst_i = 1; step(); rst_i = 0;
    endtask

    task automatic issue_long(input int bank, input int addr);
        idle(); issue_valid_i = 1; long_lat_id_i = 1; rd_wen_id_i = 1;
        rd_bank_id_i = BW'(bank); rd_addr_id_i = 5'(addr);
    endtask

    initial begin
        idle();
        model_clear();
        rst_i = 1;
        @(negedge clk); @(negedge clk);
        rst_i = 0;
        step();
        check("rst_cnt",   32'(pending_cnt_o), 32'd0);
        check("rst_stall", 32'(stall_id_o), 32'd0);

        // Long-latency f3, then a consumer of f3 waits for its writeback.
        issue_long(1, 3); step();
        idle(); issue_valid_i = 1; rd_wen_id_i = 1; rd_bank_id_i = 1; rd_addr_id_i = 4;
        rs_used_id_i[0] = 1; rs_bank_id_i[0] = 1; rs_addr_id_i[0] = 3;
        step();
        check("raw_stall", 32'(stall_id_o), 32'd1);
        step();
        lat_wb_valid_i = 1; lat_wb_bank_i = 1; lat_wb_addr_i = 3; step();
        lat_wb_valid_i = 0; step();
        check("raw_release", 32'(stall_id_o), 32'd0);

        // Load-use on rs2, then forward from MEM read data.
        do_reset();
        idle(); issue_valid_i = 1; rd_addr_ex_i = 5; reg_mem_wen_ex_i = 1;
        rs_used_id_i[1] = 1; rs_addr_id_i[1] = 5; step();
        reg_mem_wen_ex_i = 0; rd_addr_mem_i = 5; reg_mem_wen_mem_i = 1; step();
        check("lu_fwd", 32'(fwd_o[1]), 32'(FWD_MEM_RDATA_TO_ID));

        // x0 never matches; f0 does.
        issue_long(0, 0); rs_used_id_i = '1; reg_alu_wen_ex_i = 1; step();
        issue_long(1, 0); rs_used_id_i = '1; rs_bank_id_i = '1; reg_alu_wen_ex_i = 1;
        rd_bank_ex_i = 1; step();
        check("f0_fwd", 32'(fwd_o[0]), 32'(FWD_EX_ALU_RES_TO_ID));

        // Fill the scoreboard, then overflow attempt and writeback+issue.
        do_reset();
        for (int i = 1; i <= 4; i++) begin issue_long(0, i); step(); end
        check("fill_cnt",  32'(pending_cnt_o), 32'd4);
        check("fill_full", 32'(sb_full_o), 32'd1);
        issue_long(0, 5); step();
        issue_long(0, 6); lat_wb_valid_i = 1; lat_wb_addr_i = 1; step();
        idle(); step();

        // EX beats WB on the same register.
        idle(); rd_addr_ex_i = 7; reg_alu_wen_ex_i = 1; rd_addr_wb_i = 7; reg_alu_wen_wb_i = 1;
        rs_used_id_i[2] = 1; rs_addr_id_i[2] = 7; step();
        check("prio_fwd", 32'(fwd_o[2]), 32'(FWD_EX_ALU_RES_TO_ID));

        // Flush with a concurrent issue.
        do_reset();
        for (int i = 1; i <= 3; i++) begin issue_long(0, i); step(); end
        issue_long(0, 4); flush_pending_i = 1; step();
        check("flush_cnt", 32'(pending_cnt_o), 32'd0);
        idle(); issue_valid_i = 1; rd_wen_id_i = 1; rd_addr_id_i = 4;
        rs_used_id_i = '1; rs_addr_id_i[0] = 1; rs_addr_id_i[1] = 2; rs_addr_id_i[2] = 3; step();

        // Randomized traffic over a small register window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            rst_i             = ($urandom_range(0, 199) == 0);
            flush_pending_i   = ($urandom_range(0, 59) == 0);
            issue_valid_i     = ($urandom_range(0, 9) < 8);
            long_lat_id_i     = ($urandom_range(0, 9) < 4);
            rd_wen_id_i       = ($urandom_range(0, 9) < 8);
            rd_addr_id_i      = 5'($urandom_range(0, 3));
            rd_bank_id_i      = 1'($urandom_range(0, 1));
            rd_addr_ex_i      = 5'($urandom_range(0, 3));
            rd_bank_ex_i      = 1'($urandom_range(0, 1));
            reg_alu_wen_ex_i  = ($urandom_range(0, 3) == 0);
            reg_mem_wen_ex_i  = ($urandom_range(0, 5) == 0);
            rd_addr_mem_i     = 5'($urandom_range(0, 3));
            rd_bank_mem_i     = 1'($urandom_range(0, 1));
            reg_alu_wen_mem_i = ($urandom_range(0, 3) == 0);
            reg_mem_wen_mem_i = ($urandom_range(0, 3) == 0);
            rd_addr_wb_i      = 5'($urandom_range(0, 3));
            rd_bank_wb_i      = 1'($urandom_range(0, 1));
            reg_alu_wen_wb_i  = ($urandom_range(0, 3) == 0);
            reg_mem_wen_wb_i  = ($urandom_range(0, 3) == 0);
            lat_wb_valid_i    = ($urandom_range(0, 9) < 3);
            lat_wb_addr_i     = 5'($urandom_range(0, 3));
            lat_wb_bank_i     = 1'($urandom_range(0, 1));
            for (int s = 0; s < NS; s++) begin
                rs_addr_id_i[s] = 5'($urandom_range(0, 3));
                rs_bank_id_i[s] = 1'($urandom_range(0, 1));
                rs_used_id_i[s] = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
